// File: rtl/fifo_serial_reader.sv
// Read side of the DAQ sample FIFO: pops one word at a time and shifts it out MSB-first
// on a cs_n/sclk/sdo link (SPI mode 0), with a fixed inter-word gap and a word counter.
module fifo_serial_reader #(
  parameter int DATA_LENGTH = 16,
  parameter int CLK_DIV     = 2,
  parameter int GAP_CYCLES  = 2,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   fifo_empty,
  input  logic [DATA_LENGTH-1:0] fifo_o_data,
  output logic                   fifo_read,
  output logic                   cs_n,
  output logic                   sclk,
  output logic                   sdo,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] words_sent
);

  localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int DIV_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = (DATA_LENGTH > 2) ? $clog2(DATA_LENGTH) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] GAP_LAST = DIV_W'(GAP_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_TOP  = BIT_W'(DATA_LENGTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    POP,
    SHIFT_LO,
    SHIFT_HI,
    GAP
  } state_t;

  state_t                   state_q, state_d;
  logic [DATA_LENGTH-1:0]   shreg_q, shreg_d;
  logic [BIT_W-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]         div_cnt_q, div_cnt_d;
  logic [COUNT_WIDTH-1:0]   words_sent_q, words_sent_d;
  logic                     fifo_read_q, fifo_read_d;
  logic                     cs_n_q, cs_n_d;
  logic                     sclk_q, sclk_d;
  logic                     sdo_q, sdo_d;
  logic                     busy_q, busy_d;

  // div_cnt times both the sclk half-periods and the inter-word gap
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    div_cnt_d    = div_cnt_q;
    words_sent_d = words_sent_q;

    unique case (state_q)
      IDLE: begin
        div_cnt_d = '0;
        if (enable && !fifo_empty) begin
          shreg_d   = fifo_o_data;
          bit_cnt_d = BIT_TOP;
          state_d   = POP;
        end
      end
      POP: begin
        div_cnt_d = '0;
        state_d   = SHIFT_LO;
      end
      SHIFT_LO: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          state_d   = SHIFT_HI;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      SHIFT_HI: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          if (bit_cnt_q == '0) begin
            words_sent_d = words_sent_q + 1'b1;
            state_d      = GAP;
          end else begin
            shreg_d   = {shreg_q[DATA_LENGTH-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q - 1'b1;
            state_d   = SHIFT_LO;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (div_cnt_q == GAP_LAST) begin
          div_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      default: begin
        div_cnt_d = '0;
        state_d   = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so each one lands in a flop alongside state_q
  always_comb begin
    fifo_read_d = (state_d == POP);
    cs_n_d      = !((state_d == SHIFT_LO) || (state_d == SHIFT_HI));
    sclk_d      = (state_d == SHIFT_HI);
    sdo_d       = ((state_d == SHIFT_LO) || (state_d == SHIFT_HI)) ? shreg_d[DATA_LENGTH-1] : 1'b0;
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      div_cnt_q    <= '0;
      words_sent_q <= '0;
      fifo_read_q  <= 1'b0;
      cs_n_q       <= 1'b1;
      sclk_q       <= 1'b0;
      sdo_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      div_cnt_q    <= div_cnt_d;
      words_sent_q <= words_sent_d;
      fifo_read_q  <= fifo_read_d;
      cs_n_q       <= cs_n_d;
      sclk_q       <= sclk_d;
      sdo_q        <= sdo_d;
      busy_q       <= busy_d;
    end
  end

  assign fifo_read  = fifo_read_q;
  assign cs_n       = cs_n_q;
  assign sclk       = sclk_q;
  assign sdo        = sdo_q;
  assign busy       = busy_q;
  assign words_sent = words_sent_q;

endmodule
